bin2bcd: RTL and testbench

Sequential double-dabble binary-to-BCD converter for the calculator datapath. It sits directly downstream of the serial divider and converts a quotient or remainder into packed decimal digits for the display driver, using one bit per clock. It presents the same idle/valid handshake as the divider, so the two chain without glue. It also produces a leading-zero blanking mask for the display.

---
 rtl/bin2bcd.sv | 112 +++++++++++
 tb/tb_bin2bcd.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd.sv
// bin2bcd: sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Uses the same idle/valid handshake as the serial divider and adds a
// leading-zero blanking mask for the display driver.
module bin2bcd #(
  parameter int unsigned BITS   = 4,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BITS-1:0]       BIN,
  input  logic                  input_vld,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  output_vld
);

  localparam int unsigned CntW = $clog2(BITS + 1);
  localparam longint unsigned MaxVal = (64'd1 << BITS) - 64'd1;

  function automatic longint unsigned pow10(int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // Reject parameterisations whose digit count cannot hold the largest input.
  if (BITS < 1) begin : g_bad_bits
    $error("bin2bcd: BITS must be at least 1");
  end
  if (pow10(DIGITS) <= MaxVal) begin : g_bad_digits
    $error("bin2bcd: DIGITS too small for BITS");
  end

  typedef enum logic {StIdle, StConv} state_e;

  state_e                state_q, state_d;
  logic [BITS-1:0]       sh_q, sh_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [4*DIGITS-1:0]   bcd_adj;

  // Add-3 correction on every digit >= 5, digits kept independent (no carries).
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state logic: accept in idle, one corrected shift per cycle while converting.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (input_vld) begin
          sh_d    = BIN;
          bcd_d   = '0;
          cnt_d   = CntW'(BITS);
          state_d = StConv;
        end
      end
      StConv: begin
        bcd_d = {bcd_adj[4*DIGITS-2:0], sh_q[BITS-1]};
        sh_d  = sh_q << 1;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset discards any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  // Blanking mask: digit i shown if it or any more significant digit is nonzero.
  always_comb begin
    logic nz;
    digit_en = '0;
    nz       = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      nz          = nz | (bcd_q[4*i +: 4] != 4'd0);
      digit_en[i] = nz;
    end
    digit_en[0] = 1'b1;
  end

  assign BCD        = bcd_q;
  assign output_vld = (state_q == StIdle);

endmodule

// File: tb/tb_bin2bcd.sv
// tb_bin2bcd: directed-vector bench for bin2bcd at 4/2 and 8/3 parameterisations.
module tb_bin2bcd;

  logic        clk;
  logic        rst_n;

  logic [3:0]  bin4;
  logic        vld4;
  logic [7:0]  bcd4;
  logic [1:0]  en4;
  logic        ovld4;

  logic [7:0]  bin8;
  logic        vld8;
  logic [11:0] bcd8;
  logic [2:0]  en8;
  logic        ovld8;

  int n_vec;
  int n_err;

  bin2bcd #(.BITS(4), .DIGITS(2)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .BIN        (bin4),
    .input_vld  (vld4),
    .BCD        (bcd4),
    .digit_en   (en4),
    .output_vld (ovld4)
  );

  bin2bcd #(.BITS(8), .DIGITS(3)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .BIN        (bin8),
    .input_vld  (vld8),
    .BCD        (bcd8),
    .digit_en   (en8),
    .output_vld (ovld8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Convert on the 4/2 instance, checking busy length, result and mask.
  task automatic conv4(input logic [3:0] v, input logic [7:0] exp_bcd, input logic [1:0] exp_en);
    int busy;
    bin4 = v;
    vld4 = 1'b1;
    tick();
    vld4 = 1'b0;
    busy = 0;
    while (!ovld4 && busy < 20) begin
      tick();
      busy++;
    end
    check("busy4", busy, 4);
    check("bcd4", bcd4, exp_bcd);
    check("en4", en4, exp_en);
  endtask

  task automatic conv8(input logic [7:0] v, input logic [11:0] exp_bcd, input logic [2:0] exp_en);
    int busy;
    bin8 = v;
    vld8 = 1'b1;
    tick();
    vld8 = 1'b0;
    busy = 0;
    while (!ovld8 && busy < 40) begin
      tick();
      busy++;
    end
    check("busy8", busy, 8);
    check("bcd8", bcd8, exp_bcd);
    check("en8", en8, exp_en);
  endtask

  initial begin
    int busy;
    logic [3:0] q;
    logic [3:0] r;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bin4  = '0;
    vld4  = 1'b0;
    bin8  = '0;
    vld8  = 1'b0;
    tick();
    tick();
    check("rst_ovld", ovld4, 1);
    check("rst_bcd", bcd4, 8'h00);
    check("rst_en", en4, 2'b01);
    check("rst_en8", en8, 3'b001);
    rst_n = 1'b1;
    tick();

    // Abort a conversion of 15 with an asynchronous reset between edges.
    bin4 = 4'd15;
    vld4 = 1'b1;
    tick();
    vld4 = 1'b0;
    tick();
    tick();
    check("mid_busy", ovld4, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ovld", ovld4, 1);
    check("arst_bcd", bcd4, 8'h00);
    check("arst_en", en4, 2'b01);
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("post_rst_ovld", ovld4, 1);
    check("post_rst_bcd", bcd4, 8'h00);

    // Every 4-bit value.
    for (int v = 0; v < 16; v++) begin
      conv4(4'(v), 8'(((v / 10) << 4) | (v % 10)), (v >= 10) ? 2'b11 : 2'b01);
    end

    // Wide instance.
    conv8(8'd255, 12'h255, 3'b111);
    conv8(8'd100, 12'h100, 3'b111);
    conv8(8'd99,  12'h099, 3'b011);
    conv8(8'd0,   12'h000, 3'b001);

    // Busy-ignore: a request raised during conversion waits for the first idle edge.
    bin4 = 4'd7;
    vld4 = 1'b1;
    tick();                 // edge k: accept 7
    vld4 = 1'b0;
    tick();                 // k+1
    bin4 = 4'd12;
    vld4 = 1'b1;
    tick();                 // k+2
    tick();                 // k+3
    tick();                 // k+4: done with 7
    check("ign_ovld", ovld4, 1);
    check("ign_bcd", bcd4, 8'h07);
    tick();                 // k+5: accepts 12
    vld4 = 1'b0;
    check("ign_acc", ovld4, 0);
    busy = 0;
    while (!ovld4 && busy < 20) begin
      tick();
      busy++;
    end
    check("ign_busy", busy, 4);
    check("ign_bcd12", bcd4, 8'h12);

    // Back-to-back with input_vld held high.
    bin4 = 4'd3;
    vld4 = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      bin4 = (k % 2 == 0) ? 4'd14 : 4'd3;
      busy = 0;
      while (!ovld4 && busy < 20) begin
        tick();
        busy++;
      end
      check("b2b_busy", busy, 4);
      check("b2b_bcd", bcd4, (k % 2 == 0) ? 8'h03 : 8'h14);
      tick();
      check("b2b_acc", ovld4, 0);
    end
    vld4 = 1'b0;
    busy = 0;
    while (!ovld4 && busy < 20) begin
      tick();
      busy++;
    end
    check("b2b_tail", bcd4, 8'h03);

    // Divider chain: 14/4 gives quotient then remainder.
    q = 4'd14 / 4'd4;
    r = 4'd14 % 4'd4;
    conv4(q, 8'h03, 2'b01);
    conv4(r, 8'h02, 2'b01);

    // Result holds while idle.
    tick();
    tick();
    check("hold_bcd", bcd4, 8'h02);
    check("hold_ovld", ovld4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
